mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one valid/ready output channel between N requesters.

---
 rtl/mux_rr_arbiter_pkg.sv | 34 +++
 rtl/mux_rr_arbiter_if.sv | 30 +++
 rtl/mux_rr_arbiter_mux_n.sv | 53 +++++
 rtl/mux_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and round-robin search helper for mux_rr_arbiter.
// Build option: MUX_ARB_STATS_EN enables the per-requester grant counters.
package mux_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req searching last+1, last+2, ... modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [3:0]        last,
    input int                n
  );
    rr_pick_t p;
    int       i;
    p = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      i = int'(last) + k;
      if (i >= n) i = i - n;
      if (k <= n && !p.found && req[i[3:0]]) begin
        p.found = 1'b1;
        p.idx   = i[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin arbiter.
// slave = arbiter side, master = producers plus consumer side.
interface mux_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
);

  logic [N-1:0]         in_valid;
  logic [N*W-1:0]       in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic                 out_ready;
  logic [$clog2(N)-1:0] out_grant;
  logic [N*CNT_W-1:0]   grant_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_grant, grant_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_grant, grant_cnt
  );

endinterface

// File: rtl/mux_rr_arbiter_mux_n.sv
// N:1 data selector built as a binary tree of 2:1 muxes.
// Leaves past N are tied to zero so any N in 2..16 works.
module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

module mux_n #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0]       d,
  input  logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         y
);

  localparam int SW = $clog2(N);
  localparam int P  = 1 << SW;

  // Heap layout: node 0 is the root, leaves at P-1 .. 2P-2.
  logic [W-1:0] node [2*P-1];

  for (genvar j = 0; j < P; j++) begin : g_leaf
    if (j < N) begin : g_used
      assign node[P-1+j] = d[j*W +: W];
    end else begin : g_pad
      assign node[P-1+j] = '0;
    end
  end

  for (genvar l = 0; l < SW; l++) begin : g_lvl
    for (genvar m = 0; m < (1 << l); m++) begin : g_node
      localparam int K = (1 << l) - 1 + m;
      mux2 #(.W(W)) u_mux2 (
        .a (node[2*K+1]),
        .b (node[2*K+2]),
        .s (sel[SW-1-l]),
        .y (node[K])
      );
    end
  end

  assign y = node[0];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: N valid/ready requesters onto one output channel.
// Define MUX_ARB_STATS_EN to build the saturating per-requester counters.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int GW = $clog2(N);

  arb_state_t    state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] last, last_nxt;

  logic          xfer;
  logic [N-1:0]  others;
  logic [15:0]   req_all, req_oth;
  logic [3:0]    last_w, grant_w;
  rr_pick_t      pick_idle, pick_next;
  logic          hit_idle, hit_next;

  always_comb begin
    others        = bus.in_valid;
    others[grant] = 1'b0;
    req_all       = '0;
    req_oth       = '0;
    last_w        = '0;
    grant_w       = '0;
    req_all[N-1:0]  = bus.in_valid;
    req_oth[N-1:0]  = others;
    last_w[GW-1:0]  = last;
    grant_w[GW-1:0] = grant;
  end

  // After a transfer last becomes grant, so search from grant.
  assign pick_idle = rr_pick(req_all, last_w, N);
  assign pick_next = rr_pick(req_oth, grant_w, N);
  assign hit_idle  = pick_idle.found
                   && ({1'b0, pick_idle.idx} < 5'(N));
  assign hit_next  = pick_next.found
                   && ({1'b0, pick_next.idx} < 5'(N));

  assign xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N-1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (hit_idle) begin
          state_nxt = GRANT;
          grant_nxt = pick_idle.idx[GW-1:0];
        end
      end
      GRANT: begin
        if (xfer) begin
          last_nxt = grant;
          if (hit_next)
            grant_nxt = pick_next.idx[GW-1:0];
          else if (!bus.in_valid[grant])
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.in_ready  = '0;
    if (state == GRANT) begin
      bus.out_valid       = bus.in_valid[grant];
      bus.in_ready[grant] = bus.out_ready;
    end
  end

  assign bus.out_grant = grant;

  mux_n #(.N(N), .W(W)) u_mux_n (
    .d   (bus.in_data),
    .sel (grant),
    .y   (bus.out_data)
  );

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (xfer && grant == GW'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`else
  assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8, CNT_W=4).
// Expected counter values follow MUX_ARB_STATS_EN when it is defined.
module tb_mux_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;
`ifdef MUX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   errs = 0;

  logic [7:0] dat [4];
  logic [3:0] pend = '0;
  logic       prst = 1'b0;

  mux_rr_arbiter_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

  mux_rr_arbiter #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] v, input logic r);
    rst_n = 1'b0;
    bus.in_valid  = v;
    bus.out_ready = r;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
  endtask

  // A pending request must stay valid until it is accepted.
  always @(negedge clk) begin
    if (rst_n && prst) begin
      compared++;
      assert ((pend & ~bus.in_valid) == 4'b0) else begin
        errs++;
        $error("FAIL valid_drop: got %b expected %b",
               bus.in_valid, pend);
      end
    end
    pend = bus.in_valid & ~bus.in_ready;
    prst = rst_n;
  end

  initial begin
    dat[0] = 8'h3C;
    dat[1] = 8'h5B;
    dat[2] = 8'hA5;
    dat[3] = 8'hD3;
    bus.in_data   = {dat[3], dat[2], dat[1], dat[0]};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;

    // reset state with all requesters valid
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_grant", 32'(bus.out_grant), 32'h0);
    chk("rst_cnt", 32'(bus.grant_cnt), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'h1);
    chk("rel_grant", 32'(bus.out_grant), 32'h0);

    // fairness: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", 32'(bus.out_grant), 32'(k % 4));
      chk("rr_ready", 32'(bus.in_ready), 32'(1 << (k % 4)));
      chk("rr_data", 32'(bus.out_data), 32'(dat[k % 4]));
      step(1);
    end
    chk("rr_cnt", 32'(bus.grant_cnt), STATS ? 32'h2222 : 32'h0);

    // backpressure on requester 2
    do_reset(4'b0100, 1'b0);
    bus.in_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_data", 32'(bus.out_data), 32'hA5);
      chk("bp_grant", 32'(bus.out_grant), 32'h2);
      chk("bp_ready", 32'(bus.in_ready), 32'h0);
      step(1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_accept", 32'(bus.in_ready), 32'h4);
    step(1);
    bus.in_valid = 4'b0001;
    #1;
    chk("bp_next_grant", 32'(bus.out_grant), 32'h0);
    chk("bp_next_data", 32'(bus.out_data), 32'h3C);
    chk("bp_next_valid", 32'(bus.out_valid), 32'h1);

    // skip from last=3 to 2, then wrap from last=2 to 0
    do_reset(4'b0100, 1'b0);
    chk("skip_grant", 32'(bus.out_grant), 32'h2);
    bus.in_valid  = 4'b0111;
    bus.out_ready = 1'b1;
    step(1);
    bus.in_valid = 4'b0011;
    chk("wrap_grant", 32'(bus.out_grant), 32'h0);
    chk("wrap_data", 32'(bus.out_data), 32'h3C);
    step(1);
    bus.in_valid = 4'b0010;
    chk("b2b_grant", 32'(bus.out_grant), 32'h1);
    step(1);
    chk("single_grant", 32'(bus.out_grant), 32'h1);
    chk("single_valid", 32'(bus.out_valid), 32'h1);

    // reset during a stalled grant to requester 1
    do_reset(4'b0011, 1'b1);
    chk("mid_first", 32'(bus.out_grant), 32'h0);
    step(1);
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    chk("mid_grant", 32'(bus.out_grant), 32'h1);
    step(1);
    chk("mid_hold", 32'(bus.out_grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
    chk("mid_rst_grant", 32'(bus.out_grant), 32'h0);
    chk("mid_rst_cnt", 32'(bus.grant_cnt), 32'h0);
    bus.in_valid = 4'b0011;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
    chk("mid_after_grant", 32'(bus.out_grant), 32'h0);
    chk("mid_after_valid", 32'(bus.out_valid), 32'h1);

    // counter saturation on requester 1
    do_reset(4'b0010, 1'b1);
    chk("cnt_start", 32'(bus.grant_cnt), 32'h0);
    step(5);
    chk("cnt_5", 32'(bus.grant_cnt), STATS ? 32'h0050 : 32'h0);
    step(15);
    chk("cnt_sat", 32'(bus.grant_cnt), STATS ? 32'h00F0 : 32'h0);
    chk("cnt_grant", 32'(bus.out_grant), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, errs);
    $finish;
  end

endmodule
